// File: rtl/emif_pkg.sv
// Shared definitions for the EMIF command generator: command pin encodings,
// FSM state type and the phase-counter width helper.
package emif_pkg;

    // {ce, ras, cas, we}, all active-low
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_RCD,
        ST_CMD,
        ST_PRE,
        ST_GAP
    } state_t;

    // Bits needed to hold (largest phase length - 1) without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/emif_cmd_gen_if.sv
// Host request/response channel plus the EMIF pin bundle of the command generator.
interface emif_cmd_gen_if #(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int DATA_W = 16
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_wr;
    logic [ROW_W+COL_W-1:0] req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   busy;

    logic                   emif_clk;
    logic                   emif_cke;
    logic                   emif_ce;
    logic                   emif_ras;
    logic                   emif_cas;
    logic                   emif_we;
    logic [ROW_W-1:0]       emif_addr;
    logic [DATA_W-1:0]      emif_dq_o;
    logic                   emif_dq_oe;
    logic [DATA_W-1:0]      emif_dq_i;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, emif_dq_i,
        input  req_ready, rd_valid, rd_data, busy,
        input  emif_clk, emif_cke, emif_ce, emif_ras, emif_cas, emif_we,
        input  emif_addr, emif_dq_o, emif_dq_oe
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, emif_dq_i,
        output req_ready, rd_valid, rd_data, busy,
        output emif_clk, emif_cke, emif_ce, emif_ras, emif_cas, emif_we,
        output emif_addr, emif_dq_o, emif_dq_oe
    );

endinterface

// File: rtl/emif_clk_div.sv
// Free-running EMIF clock divider and clock-enable generator; runs
// independently of the command FSM.
module emif_clk_div
    import emif_pkg::*;
#(
    parameter int CLK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic emif_clk,
    output logic emif_cke
);

    localparam int DIV_W = cnt_width(CLK_HALF, 1, 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             emif_clk_q, emif_clk_d;
    logic             emif_cke_q;

    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        emif_clk_d = emif_clk_q;
        if (div_cnt_q == DIV_W'(CLK_HALF - 1)) begin
            div_cnt_d  = '0;
            emif_clk_d = ~emif_clk_q;
        end
    end

    // cke rises on the first edge after reset release and stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            emif_clk_q <= 1'b1;
            emif_cke_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            emif_clk_q <= emif_clk_d;
            emif_cke_q <= 1'b1;
        end
    end

    assign emif_clk = emif_clk_q;
    assign emif_cke = emif_cke_q;

endmodule

// File: rtl/emif_cmd_gen.sv
// EMIF initiator: turns one host read/write into ACT / NOP / READ|WRITE / PRE
// followed by a deselect gap. All pin outputs are registered.
module emif_cmd_gen
    import emif_pkg::*;
#(
    parameter int ROW_W    = 13,
    parameter int COL_W    = 9,
    parameter int DATA_W   = 16,
    parameter int T_RCD    = 4,
    parameter int T_CMD    = 6,
    parameter int CAS_LAT  = 6,
    parameter int T_IDLE   = 60,
    parameter int CLK_HALF = 2
) (
    input logic           clk,
    input logic           rst_n,
    emif_cmd_gen_if.slave bus
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int CNT_W  = cnt_width(T_RCD, T_CMD, T_IDLE);
    localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1) << 10;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [3:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  emif_addr_q, emif_addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ready_q, ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              accept;

    assign accept = bus.req_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The phase counter is reloaded on entry to every timed state and exits at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACT;
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            ST_ACT: begin
                state_d = ST_RCD;
                cnt_d   = CNT_W'(T_RCD - 2);
            end
            ST_RCD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CMD;
                    cnt_d   = CNT_W'(T_CMD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CMD: begin
                if (cnt_q == '0) state_d = ST_PRE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_PRE: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(T_IDLE - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the next state so they appear in the cycle the state begins.
    always_comb begin
        cmd_d       = CMD_DESEL;
        emif_addr_d = '0;
        dq_o_d      = '0;
        dq_oe_d     = 1'b0;
        ready_d     = (state_d == ST_IDLE);
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        case (state_d)
            ST_ACT: begin
                cmd_d       = CMD_ACT;
                emif_addr_d = addr_d[ADDR_W-1:COL_W];
            end
            ST_RCD: cmd_d = CMD_NOP;
            ST_CMD: begin
                cmd_d       = wr_d ? CMD_WRITE : CMD_READ;
                emif_addr_d = ROW_W'(addr_d[COL_W-1:0]);
                if (wr_d) begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = wdata_d;
                end
            end
            ST_PRE: begin
                cmd_d       = CMD_PRE;
                emif_addr_d = PRE_ADDR;
            end
            default: ;
        endcase
        if (state_q == ST_CMD && !wr_q && cnt_q == CNT_W'(T_CMD - CAS_LAT)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.emif_dq_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= CMD_DESEL;
            emif_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ready_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            cmd_q       <= cmd_d;
            emif_addr_q <= emif_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ready_q     <= ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign {bus.emif_ce, bus.emif_ras, bus.emif_cas, bus.emif_we} = cmd_q;
    assign bus.emif_addr  = emif_addr_q;
    assign bus.emif_dq_o  = dq_o_q;
    assign bus.emif_dq_oe = dq_oe_q;
    assign bus.req_ready  = ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = (state_q != ST_IDLE);

    emif_clk_div #(
        .CLK_HALF (CLK_HALF)
    ) u_clk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .emif_clk (bus.emif_clk),
        .emif_cke (bus.emif_cke)
    );

endmodule

// File: tb/tb_emif_cmd_gen.sv
// Randomized bench for emif_cmd_gen: a timeline model (cycles since accept)
// predicts every pin; a second instance covers the single-cycle-command corner.
module tb_emif_cmd_gen;

    localparam int ROW_W    = 13;
    localparam int COL_W    = 9;
    localparam int DATA_W   = 16;
    localparam int AW       = ROW_W + COL_W;
    localparam int T_RCD    = 4;
    localparam int T_CMD    = 6;
    localparam int CAS_LAT  = 6;
    localparam int T_IDLE   = 60;
    localparam int CLK_HALF = 2;
    localparam int TOTAL    = T_RCD + T_CMD + T_IDLE + 2;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    emif_cmd_gen_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) ab ();
    emif_cmd_gen_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bb ();

    emif_cmd_gen #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W), .T_RCD(T_RCD), .T_CMD(T_CMD),
        .CAS_LAT(CAS_LAT), .T_IDLE(T_IDLE), .CLK_HALF(CLK_HALF)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ab.slave));

    emif_cmd_gen #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W), .T_RCD(T_RCD), .T_CMD(1),
        .CAS_LAT(1), .T_IDLE(1), .CLK_HALF(CLK_HALF)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.slave));

    always #5 clk = ~clk;

    // Reference model state: mk = cycles since accept (-1 when idle).
    int                mk;
    int                m_edges;
    logic              m_ready;
    logic              m_wr;
    logic [AW-1:0]     m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rd_valid;
    logic [DATA_W-1:0] m_rd_data;
    logic [DATA_W-1:0] b_seen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_cmd(input int k, input logic wr, input int trcd, input int tcmd);
        if (k == 1) return 4'b0011;
        if (k >= 2 && k <= trcd) return 4'b0111;
        if (k > trcd && k <= trcd + tcmd) return wr ? 4'b0100 : 4'b0101;
        if (k == trcd + tcmd + 1) return 4'b0010;
        return 4'b1111;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk         = -1;
            m_ready    = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            m_edges    = 0;
        end else begin
            m_edges++;
            m_rd_valid = 1'b0;
            if (mk == T_RCD + CAS_LAT && !m_wr) begin
                m_rd_valid = 1'b1;
                m_rd_data  = ab.emif_dq_i;
            end
            if (mk > 0) begin
                mk++;
                if (mk == TOTAL) begin
                    mk      = -1;
                    m_ready = 1'b1;
                end
            end else if (m_ready && ab.req_valid) begin
                mk      = 1;
                m_ready = 1'b0;
                m_wr    = ab.req_wr;
                m_addr  = ab.req_addr;
                m_wdata = ab.req_wdata;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic in_cmd;
        in_cmd = (mk > T_RCD && mk <= T_RCD + T_CMD);
        checkOutput("cmd", 32'({ab.emif_ce, ab.emif_ras, ab.emif_cas, ab.emif_we}),
                    32'(exp_cmd(mk, m_wr, T_RCD, T_CMD)));
        checkOutput("ready", 32'(ab.req_ready), 32'(m_ready));
        checkOutput("busy", 32'(ab.busy), 32'(mk > 0));
        checkOutput("dq_oe", 32'(ab.emif_dq_oe), 32'(in_cmd && m_wr));
        checkOutput("rd_valid", 32'(ab.rd_valid), 32'(m_rd_valid));
        checkOutput("rd_data", 32'(ab.rd_data), 32'(m_rd_data));
        checkOutput("cke", 32'(ab.emif_cke), 32'(m_edges >= 1));
        checkOutput("emif_clk", 32'(ab.emif_clk), 32'(1 ^ ((m_edges / CLK_HALF) % 2)));
        if (mk == 1) checkOutput("addr_row", 32'(ab.emif_addr), 32'(m_addr[AW-1:COL_W]));
        if (in_cmd) begin
            checkOutput("addr_col", 32'(ab.emif_addr), 32'(m_addr[COL_W-1:0]));
            if (m_wr) checkOutput("dq_o", 32'(ab.emif_dq_o), 32'(m_wdata));
        end
        if (mk == T_RCD + T_CMD + 1) checkOutput("addr_pre", 32'(ab.emif_addr), 32'h400);
        if (!rst_n) begin
            checkOutput("rst_addr", 32'(ab.emif_addr), 32'h0);
            checkOutput("rst_dq_o", 32'(ab.emif_dq_o), 32'h0);
        end
    end

    always @(posedge clk) begin
        #1;
        bb.emif_dq_i = DATA_W'($urandom);
    end

    task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                                 input logic [DATA_W-1:0] d);
        ab.req_valid = v;
        ab.req_wr    = w;
        ab.req_addr  = a;
        ab.req_wdata = d;
        ab.emif_dq_i = DATA_W'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while (!m_ready && g < 300) begin
            applyStimulus(1'b0, 1'b0, AW'($urandom), DATA_W'($urandom));
            g++;
        end
        if (!m_ready) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic randomPhase(input int cycles, input bit always_valid);
        for (int i = 0; i < cycles; i++)
            applyStimulus(always_valid || ($urandom_range(0, 3) == 0), 1'($urandom),
                          AW'($urandom), DATA_W'($urandom));
    endtask

    initial begin
        int g;
        rst_n        = 1'b0;
        ab.req_valid = 1'b0; ab.req_wr = 1'b0; ab.req_addr = '0; ab.req_wdata = '0;
        ab.emif_dq_i = '0;
        bb.req_valid = 1'b0; bb.req_wr = 1'b0; bb.req_addr = '0; bb.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitIdle();

        $display("[TB] directed write and read");
        applyStimulus(1'b1, 1'b1, {13'h155, 9'h0AA}, 16'hA5C3);
        waitIdle();
        applyStimulus(1'b1, 1'b0, {13'h0F3, 9'h101}, 16'h0000);
        waitIdle();

        $display("[TB] random and back-to-back traffic");
        randomPhase(600, 1'b0);
        randomPhase(300, 1'b1);

        $display("[TB] reset during write");
        waitIdle();
        applyStimulus(1'b1, 1'b1, AW'($urandom), DATA_W'($urandom));
        g = 0;
        while (mk != 7 && g < 20) begin
            applyStimulus(1'b0, 1'b0, '0, '0);
            g++;
        end
        checkOutput("reach_cycle7", 32'(mk), 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pins", 32'({ab.emif_ce, ab.emif_ras, ab.emif_cas, ab.emif_we}), 32'hF);
        checkOutput("abort_busy", 32'(ab.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, AW'($urandom), DATA_W'($urandom));
        randomPhase(200, 1'b0);
        waitIdle();

        $display("[TB] single-cycle command instance");
        checkOutput("b_ready", 32'(bb.req_ready), 32'd1);
        bb.req_valid = 1'b1;
        bb.req_wr    = 1'b0;
        bb.req_addr  = AW'($urandom);
        @(posedge clk);
        #1;
        bb.req_valid = 1'b0;
        for (int k = 1; k <= T_RCD + 4; k++) begin
            @(negedge clk);
            checkOutput("b_cmd", 32'({bb.emif_ce, bb.emif_ras, bb.emif_cas, bb.emif_we}),
                        32'(exp_cmd(k, 1'b0, T_RCD, 1)));
            checkOutput("b_ready_k", 32'(bb.req_ready), 32'(k == T_RCD + 4));
            checkOutput("b_rd_valid", 32'(bb.rd_valid), 32'(k == T_RCD + 2));
            if (k == T_RCD + 1) b_seen = bb.emif_dq_i;
            if (k == T_RCD + 2) checkOutput("b_rd_data", 32'(bb.rd_data), 32'(b_seen));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emif_cmd_gen.md
Name: emif_cmd_gen

Overview:
- FPGA-side EMIF initiator. Converts a single-beat host request (write or read) into an SDRAM-style EMIF command sequence on ce/ras/cas/we, with address and data buses.
- It is the transmit end of the EMIF strobe interface that the board's input synchronisers decode. Write strobes hold we+cas low for T_CMD clk cycles, and each access is followed by a ≥T_IDLE-cycle deselect gap so the far end sees its idle window.
- Used for board-to-board links and loopback self-test of the EMIF input path.

Parameters:
- ROW_W, 13, row address width
- COL_W, 9, column address width
- DATA_W, 16, data bus width
- T_RCD, 4, clk cycles from ACTIVE to READ/WRITE (≥2)
- T_CMD, 6, clk cycles READ/WRITE command is held (≥1)
- CAS_LAT, 6, clk cycles from READ command start to data sample (1..T_CMD)
- T_IDLE, 60, deselect gap in clk cycles after PRECHARGE (≥1)
- CLK_HALF, 2, clk cycles per half period of emif_clk (≥1)

Ports:
- clk  in  1  200 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE; a request is accepted when valid&&ready
- req_wr  in  1  1=write, 0=read
- req_addr  in  ROW_W+COL_W  {row,col}
- req_wdata  in  DATA_W  write data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  captured read data, held until next capture
- busy  out  1  high in any state other than IDLE
- emif_clk  out  1  free-running, toggles every CLK_HALF clk
- emif_cke  out  1  0 in reset, 1 from the first clk after reset release
- emif_ce  out  1  active-low chip enable
- emif_ras  out  1  active-low
- emif_cas  out  1  active-low
- emif_we  out  1  active-low
- emif_addr  out  ROW_W  multiplexed row/column (column zero-extended)
- emif_dq_o  out  DATA_W  write data
- emif_dq_oe  out  1  data bus output enable
- emif_dq_i  in  DATA_W  read data input, sampled directly (source-synchronous to clk by design)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: ce/ras/cas/we=1, emif_clk=1, emif_cke=0, emif_addr=0, dq_o=0, dq_oe=0, rd_valid=0, rd_data=0, req_ready=0 in reset (1 on the first cycle after release), busy=0. State returns to IDLE.
- Reset mid-access aborts immediately. All command pins go to 1 and no PRECHARGE is issued.
- Command encodings (ce,ras,cas,we): DESEL=1111, NOP=0111, ACT=0011, WRITE=0100, READ=0101, PRE=0010. All command outputs are registered.
- FSM and transitions:
  - IDLE: DESEL. On accept, latch wr/addr/wdata and go to ACT. Requests are never queued.
  - ACT: 1 cycle ACT, emif_addr=row. Then RCD.
  - RCD: NOP for T_RCD-1 cycles. Then CMD.
  - CMD: WRITE or READ for T_CMD cycles, emif_addr={0,col}.
    - On WRITE, dq_oe=1 and dq_o=wdata for exactly these T_CMD cycles.
    - On READ, emif_dq_i is sampled on command-cycle index CAS_LAT (first CMD cycle = 1). rd_valid pulses the following cycle.
    - Then PRE.
  - PRE: 1 cycle PRE, emif_addr[10]=1 (all banks), other bits 0. Then GAP.
  - GAP: DESEL for T_IDLE cycles. Then IDLE.
- Latency: accept at cycle 0 → ACT visible at cycle 1 → WRITE/READ first visible at cycle T_RCD+1 → PRE at T_RCD+T_CMD+1 → req_ready high again at T_RCD+T_CMD+T_IDLE+2. With defaults, ready returns at cycle 72.
- Phase counter: one down-counter sized for max(T_RCD,T_CMD,T_IDLE) and reloaded on each state entry. No wrap-around is permitted.
- req_valid during busy is ignored. Payload inputs are don't-care except in the accept cycle.
- emif_clk is independent of the FSM. Its divider counter wraps at CLK_HALF-1.

Decomposition:
- Package emif_pkg: command encoding constants (DESEL..PRE), state enum, and a counter-width function.
- Sub-module emif_clk_div: emif_clk/emif_cke generation from CLK_HALF. Everything else stays in the top module.

Test Plan:
- Reset held then released → all command pins 1, cke 0 during reset; cke 1 and ready 1 one cycle after release; emif_clk period 4 clk.
- Write addr {row=0x155,col=0x0AA}, data 0xA5C3 → ACT at +1 with addr 0x155; WRITE 0100 at cycles 5..10 with addr 0x0AA, dq_oe=1, dq_o=0xA5C3; PRE at 11 with addr[10]=1; ready at 72.
- Read with emif_dq_i=0x1234 from cycle 10 only → READ 0101 at cycles 5..10; rd_data=0x1234 and one-cycle rd_valid at cycle 11; dq_oe stays 0.
- req_valid held high continuously → exactly one ACT per 72 cycles; gap of ≥60 DESEL cycles between PRE and the next ACT.
- rst_n asserted at cycle 7 of a write → pins 1111 immediately, no PRE; a new request after release starts a clean ACT.
- Parameters T_CMD=1, CAS_LAT=1, T_IDLE=1 → single-cycle command, sample in that cycle, ready returns at T_RCD+4.
